// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types for the two-port SRAM arbiter.
//   port_e     - requester index (imem = 0, dmem = 1)
//   rsp_tag_t  - one-deep response tag {valid, port, is_write}
//   addr_shift - byte-address to word-address shift for a data width
package sram_arb_pkg;

    typedef enum logic {
        PORT_IMEM = 1'b0,
        PORT_DMEM = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  is_write;
    } rsp_tag_t;

    // Number of low byte-address bits dropped to form a word address.
    function automatic int unsigned addr_shift(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter with starvation override.
//   req_i        - request vector {dmem, imem}
//   last_i       - winner of the last contended grant
//   cnt_imem_i   - imem consecutive contended-loss count
//   cnt_dmem_i   - dmem consecutive contended-loss count
//   grant_o      - one-hot grant {dmem, imem}
//   last_we_o    - strobe: load win_o into the last-winner register
//   win_o        - contended winner (valid with last_we_o)
//   cnt_inc_o    - per-port loss counter increment strobes
//   cnt_clr_o    - per-port loss counter clear strobes
module rr_arb2
    import sram_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3,
    parameter bit          FAVOR_DMEM = 1'b0
) (
    input  logic [1:0]       req_i,
    input  port_e            last_i,
    input  logic [CNT_W-1:0] cnt_imem_i,
    input  logic [CNT_W-1:0] cnt_dmem_i,
    output logic [1:0]       grant_o,
    output logic             last_we_o,
    output port_e            win_o,
    output logic [1:0]       cnt_inc_o,
    output logic [1:0]       cnt_clr_o
);

    logic starve_imem;
    logic starve_dmem;

    assign starve_imem = (cnt_imem_i >= CNT_W'(STARVE_MAX));
    assign starve_dmem = (cnt_dmem_i >= CNT_W'(STARVE_MAX));

    // Decision: starvation first, then rotation (or the dmem-favouring hook).
    always_comb begin
        grant_o   = 2'b00;
        last_we_o = 1'b0;
        win_o     = PORT_IMEM;
        cnt_inc_o = 2'b00;
        cnt_clr_o = 2'b00;
        if (&req_i) begin
            if (starve_imem) begin
                win_o = PORT_IMEM;
            end else if (starve_dmem) begin
                win_o = PORT_DMEM;
            end else if (FAVOR_DMEM) begin
                win_o = PORT_DMEM;
            end else begin
                win_o = (last_i == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
            end
            last_we_o = 1'b1;
            if (win_o == PORT_DMEM) begin
                grant_o      = 2'b10;
                cnt_clr_o    = 2'b10;
                cnt_inc_o[0] = ~starve_imem;
            end else begin
                grant_o      = 2'b01;
                cnt_clr_o    = 2'b01;
                cnt_inc_o[1] = ~starve_dmem;
            end
        end else begin
            // Single or no requester: pass through, priority untouched.
            grant_o   = req_i;
            cnt_clr_o = req_i;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between an instruction
// (read-only) and a data requester with zero-cycle acceptance.
//   i_clk, i_rst           - clock, synchronous active-high reset
//   imem_req/addr          - port 0 request (read only)
//   dmem_req/addr/wdata/we - port 1 request
//   imem_ack, dmem_ack     - request accepted this cycle (combinational)
//   *_rvalid, *_rdata      - response, one cycle after ack
//   mem_addr/wdata/we/ce   - SRAM command (combinational)
//   mem_rdata              - SRAM read data, one cycle after a read
// TEST_FAVOR_DMEM is a test hook that replaces rotation with fixed dmem
// priority so the starvation override can be exercised.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned STARVE_MAX      = 4,
    parameter bit          TEST_FAVOR_DMEM = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic              dmem_req,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_we,
    output logic              imem_ack,
    output logic              dmem_ack,
    output logic              imem_rvalid,
    output logic              dmem_rvalid,
    output logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_ce,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned SHIFT = addr_shift(DATA_W);
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [1:0]        req_v;
    logic [1:0]        grant;
    logic              last_we;
    port_e             win;
    logic [1:0]        cnt_inc;
    logic [1:0]        cnt_clr;
    port_e             last_q, last_d;
    logic [CNT_W-1:0]  cnt_imem_q, cnt_imem_d;
    logic [CNT_W-1:0]  cnt_dmem_q, cnt_dmem_d;
    rsp_tag_t          tag_q, tag_d;
    logic              sel_dmem;
    logic [ADDR_W-1:0] sel_addr;

    // No grants while reset is held.
    assign req_v = {dmem_req, imem_req} & {2{~i_rst}};

    rr_arb2 #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W),
        .FAVOR_DMEM (TEST_FAVOR_DMEM)
    ) u_rr_arb2 (
        .req_i      (req_v),
        .last_i     (last_q),
        .cnt_imem_i (cnt_imem_q),
        .cnt_dmem_i (cnt_dmem_q),
        .grant_o    (grant),
        .last_we_o  (last_we),
        .win_o      (win),
        .cnt_inc_o  (cnt_inc),
        .cnt_clr_o  (cnt_clr)
    );

    // Command mux, arbiter state update and response-tag capture.
    always_comb begin
        sel_dmem   = grant[1];
        imem_ack   = grant[0];
        dmem_ack   = grant[1];
        mem_ce     = |grant;
        sel_addr   = sel_dmem ? dmem_addr : imem_addr;
        mem_addr   = sel_addr >> SHIFT;
        mem_we     = sel_dmem & dmem_we;
        mem_wdata  = mem_we ? dmem_wdata : '0;

        last_d     = last_we ? win : last_q;
        cnt_imem_d = cnt_imem_q;
        cnt_dmem_d = cnt_dmem_q;
        if (cnt_clr[0]) cnt_imem_d = '0;
        else if (cnt_inc[0]) cnt_imem_d = cnt_imem_q + CNT_W'(1);
        if (cnt_clr[1]) cnt_dmem_d = '0;
        else if (cnt_inc[1]) cnt_dmem_d = cnt_dmem_q + CNT_W'(1);

        tag_d.valid    = mem_ce;
        tag_d.port     = sel_dmem ? PORT_DMEM : PORT_IMEM;
        tag_d.is_write = mem_we;
    end

    // Reset leaves imem as last winner so dmem takes the first contention.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q     <= PORT_IMEM;
            cnt_imem_q <= '0;
            cnt_dmem_q <= '0;
            tag_q      <= '0;
        end else begin
            last_q     <= last_d;
            cnt_imem_q <= cnt_imem_d;
            cnt_dmem_q <= cnt_dmem_d;
            tag_q      <= tag_d;
        end
    end

    // Response steering; write responses carry zero data.
    assign imem_rvalid = tag_q.valid & (tag_q.port == PORT_IMEM);
    assign dmem_rvalid = tag_q.valid & (tag_q.port == PORT_DMEM);
    assign imem_rdata  = (imem_rvalid & ~tag_q.is_write) ? mem_rdata : '0;
    assign dmem_rdata  = (dmem_rvalid & ~tag_q.is_write) ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter with a behavioural SRAM model.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        imem_req, dmem_req, dmem_we;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata;
    logic        imem_ack, dmem_ack, imem_rvalid, dmem_rvalid;
    logic [31:0] imem_rdata, dmem_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we, mem_ce;
    logic [31:0] mem_rdata;

    // Second instance: STARVE_MAX=2 with rotation overridden toward dmem.
    logic        s_rst, s_imem_req, s_dmem_req, s_dmem_we;
    logic [31:0] s_imem_addr, s_dmem_addr, s_dmem_wdata, s_mem_rdata;
    logic        s_imem_ack, s_dmem_ack, s_imem_rvalid, s_dmem_rvalid;
    logic [31:0] s_imem_rdata, s_dmem_rdata, s_mem_addr, s_mem_wdata;
    logic        s_mem_we, s_mem_ce;

    int checks   = 0;
    int failures = 0;

    sram_port_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_rvalid(imem_rvalid), .dmem_rvalid(dmem_rvalid),
        .imem_rdata(imem_rdata), .dmem_rdata(dmem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_ce(mem_ce), .mem_rdata(mem_rdata)
    );

    sram_port_arbiter #(.STARVE_MAX(2), .TEST_FAVOR_DMEM(1'b1)) dut_s (
        .i_clk(clk), .i_rst(s_rst),
        .imem_req(s_imem_req), .imem_addr(s_imem_addr),
        .dmem_req(s_dmem_req), .dmem_addr(s_dmem_addr),
        .dmem_wdata(s_dmem_wdata), .dmem_we(s_dmem_we),
        .imem_ack(s_imem_ack), .dmem_ack(s_dmem_ack),
        .imem_rvalid(s_imem_rvalid), .dmem_rvalid(s_dmem_rvalid),
        .imem_rdata(s_imem_rdata), .dmem_rdata(s_dmem_rdata),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_we(s_mem_we), .mem_ce(s_mem_ce), .mem_rdata(s_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: unwritten word w reads back as w; writes echo on rdata.
    logic [31:0] mem [0:255];
    bit   [255:0] wr_mask;
    logic [7:0]  widx;
    assign widx = 8'(mem_addr);

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                mem[widx]     <= mem_wdata;
                wr_mask[widx] <= 1'b1;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= wr_mask[widx] ? mem[widx] : 32'(widx);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  ack_total;
        bit  exp_d;
        bit  exp_i;

        rst = 1'b1; imem_req = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0;
        imem_addr = '0; dmem_addr = '0; dmem_wdata = '0;
        s_rst = 1'b1; s_imem_req = 1'b0; s_dmem_req = 1'b0; s_dmem_we = 1'b0;
        s_imem_addr = 32'h4; s_dmem_addr = 32'h8; s_dmem_wdata = '0; s_mem_rdata = '0;

        // Requests during reset are not acknowledged.
        @(negedge clk);
        imem_req = 1'b1; dmem_req = 1'b1; imem_addr = 32'h10; dmem_addr = 32'h20;
        #1;
        chk("rst_imem_ack", 64'(imem_ack), 64'd0);
        chk("rst_dmem_ack", 64'(dmem_ack), 64'd0);
        chk("rst_mem_ce",   64'(mem_ce),   64'd0);
        @(negedge clk); #1;
        chk("rst_rvalid", 64'(imem_rvalid | dmem_rvalid), 64'd0);

        // First contended grant after reset goes to dmem.
        @(negedge clk); rst = 1'b0; #1;
        chk("c0_dmem_ack", 64'(dmem_ack), 64'd1);
        chk("c0_imem_ack", 64'(imem_ack), 64'd0);
        chk("c0_mem_addr", 64'(mem_addr), 64'h8);
        chk("c0_rvalid",   64'(imem_rvalid | dmem_rvalid), 64'd0);

        @(negedge clk); dmem_req = 1'b0; #1;
        chk("c1_imem_ack",    64'(imem_ack),    64'd1);
        chk("c1_mem_addr",    64'(mem_addr),    64'h4);
        chk("c1_dmem_rvalid", 64'(dmem_rvalid), 64'd1);
        chk("c1_dmem_rdata",  64'(dmem_rdata),  64'h8);
        chk("c1_imem_rvalid", 64'(imem_rvalid), 64'd0);

        @(negedge clk); imem_req = 1'b0; #1;
        chk("c2_imem_rvalid", 64'(imem_rvalid), 64'd1);
        chk("c2_imem_rdata",  64'(imem_rdata),  64'h4);
        chk("c2_mem_ce",      64'(mem_ce),      64'd0);

        // Idle cycle.
        @(negedge clk); #1;
        chk("idle_mem_ce",  64'(mem_ce), 64'd0);
        chk("idle_mem_we",  64'(mem_we), 64'd0);
        chk("idle_rvalid",  64'(imem_rvalid | dmem_rvalid), 64'd0);

        // dmem write followed by imem read of the same word.
        @(negedge clk);
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h40; dmem_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_dmem_ack",  64'(dmem_ack),  64'd1);
        chk("wr_mem_we",    64'(mem_we),    64'd1);
        chk("wr_mem_addr",  64'(mem_addr),  64'h10);
        chk("wr_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);

        @(negedge clk);
        dmem_req = 1'b0; dmem_we = 1'b0; imem_req = 1'b1; imem_addr = 32'h40;
        #1;
        chk("rd_imem_ack",     64'(imem_ack),    64'd1);
        chk("rd_mem_we",       64'(mem_we),      64'd0);
        chk("rd_mem_wdata",    64'(mem_wdata),   64'd0);
        chk("wrsp_dmem_rvalid",64'(dmem_rvalid), 64'd1);
        chk("wrsp_dmem_rdata", 64'(dmem_rdata),  64'd0);
        chk("wrsp_imem_rvalid",64'(imem_rvalid), 64'd0);

        @(negedge clk); imem_req = 1'b0; #1;
        chk("rrsp_imem_rvalid", 64'(imem_rvalid), 64'd1);
        chk("rrsp_imem_rdata",  64'(imem_rdata),  64'hDEADBEEF);
        chk("rrsp_dmem_rvalid", 64'(dmem_rvalid), 64'd0);

        // Two contended grants leave dmem as last winner, then reset.
        @(negedge clk);
        imem_req = 1'b1; dmem_req = 1'b1; imem_addr = 32'h100; dmem_addr = 32'h200;
        #1;
        chk("a1_imem_ack", 64'(imem_ack), 64'd1);
        chk("a1_dmem_ack", 64'(dmem_ack), 64'd0);
        @(negedge clk); #1;
        chk("a2_dmem_ack",    64'(dmem_ack),    64'd1);
        chk("a2_imem_rvalid", 64'(imem_rvalid), 64'd1);
        chk("a2_imem_rdata",  64'(imem_rdata),  64'h40);
        @(negedge clk); rst = 1'b1; #1;
        chk("rst2_acks", 64'(imem_ack | dmem_ack), 64'd0);
        @(negedge clk); rst = 1'b0; imem_req = 1'b0; dmem_req = 1'b0; #1;
        chk("post_rst_rvalid", 64'(imem_rvalid | dmem_rvalid), 64'd0);

        // Continuous contention: dmem, imem, dmem, ... with responses in order.
        ack_total = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); imem_req = 1'b1; dmem_req = 1'b1; #1;
            exp_d = ((k % 2) == 0);
            chk($sformatf("alt%0d_dmem_ack", k), 64'(dmem_ack), 64'(exp_d));
            chk($sformatf("alt%0d_imem_ack", k), 64'(imem_ack), 64'(!exp_d));
            if (k == 0) begin
                chk("alt0_rvalid", 64'(imem_rvalid | dmem_rvalid), 64'd0);
            end else begin
                chk($sformatf("alt%0d_dmem_rvalid", k), 64'(dmem_rvalid), 64'(!exp_d));
                chk($sformatf("alt%0d_imem_rvalid", k), 64'(imem_rvalid), 64'(exp_d));
                if (exp_d)
                    chk($sformatf("alt%0d_imem_rdata", k), 64'(imem_rdata), 64'h40);
                else
                    chk($sformatf("alt%0d_dmem_rdata", k), 64'(dmem_rdata), 64'h80);
            end
            ack_total += int'(imem_ack) + int'(dmem_ack);
        end
        @(negedge clk); imem_req = 1'b0; dmem_req = 1'b0; #1;
        chk("alt_end_imem_rvalid", 64'(imem_rvalid), 64'd1);
        chk("alt_end_dmem_rvalid", 64'(dmem_rvalid), 64'd0);
        chk("alt_ack_total",       64'(ack_total),   64'd8);

        // Starvation override: imem forced every third contended cycle.
        for (int j = 0; j < 6; j++) begin
            @(negedge clk); s_rst = 1'b0; s_imem_req = 1'b1; s_dmem_req = 1'b1; #1;
            exp_i = ((j % 3) == 2);
            chk($sformatf("starve%0d_imem_ack", j), 64'(s_imem_ack), 64'(exp_i));
            chk($sformatf("starve%0d_dmem_ack", j), 64'(s_dmem_ack), 64'(!exp_i));
        end
        @(negedge clk); s_imem_req = 1'b0; s_dmem_req = 1'b0; #1;
        chk("starve_idle_ce", 64'(s_mem_ce), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
